axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Stream master port between N_SRC AXI-Stream source ports.
- Grants one source at a time for a burst of at most BURST_LEN beats.
- Sits between several AXIS_Source-style producers and a single downstream consumer (skid_buffer or AXIS_Sink).
- Pass-through datapath (combinational mux); arbitration state is registered.

Parameters:
- N_SRC, 4, number of requesting source ports; 2..16, need not be a power of 2.
- WORD_W, 8, word width in bits.
- BUS_W, 32, beat width in bits; a multiple of WORD_W.
- BURST_LEN, 4, maximum accepted beats per grant; at least 1.
- GNT_W, $clog2(N_SRC), width of the grant index (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- s_valid  in  N_SRC  per-source valid.
- s_ready  out  N_SRC  per-source ready.
- s_data  in  N_SRC x BUS_W  per-source beat, packed [N_SRC-1:0][BUS_W-1:0].
- m_valid  out  1  master valid.
- m_ready  in  1  master ready.
- m_data  out  BUS_W  master beat.
- m_grant  out  GNT_W  index of the granted source; meaningful only while busy=1.
- busy  out  1  high in GRANT state.

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous active-low.
- Reset state: state=IDLE, ptr=0, grant=0, cnt=0.
- Outputs under reset: s_ready=0, m_valid=0, m_data=0, m_grant=0, busy=0.
- IDLE state:
  - s_ready=0, m_valid=0, m_data=0.
  - If any s_valid is high, latch grant = the first set index searching from ptr upward, wrapping modulo N_SRC. Also set cnt=0 and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT state outputs:
  - busy=1 and m_grant=grant.
  - m_valid=s_valid[grant] and m_data=s_data[grant].
  - s_ready[grant]=m_ready; every other s_ready bit is 0.
  - All three are combinational; there is zero added latency on the data path.
- Beat counting: a beat is accepted when m_valid && m_ready. Each accepted beat increments cnt.
- Leaving GRANT (release) happens on either condition below:
  - (a) A beat is accepted while cnt==BURST_LEN-1.
  - (b) s_valid[grant]==0 in a GRANT cycle. This is an early release; no beat is transferred that cycle.
- On release: next state is IDLE, ptr becomes (grant+1) mod N_SRC, and cnt becomes 0.
- Arbitration cost: each grant costs exactly one IDLE bubble cycle, so the maximum throughput is BURST_LEN/(BURST_LEN+1).
- Backpressure: while m_ready is low with valid high, hold grant, cnt and all outputs stable. m_data must stay stable because the source holds its data.
- Fairness: a source that is continuously valid is granted again no later than after N_SRC-1 other grants.
- Single requester: it is re-granted after its own bubble cycle.
- Simultaneous requests entering IDLE: only the round-robin winner is granted. Requests that assert in the release cycle itself are seen in the following IDLE cycle.
- Reset mid-burst: outputs drop to their reset values immediately (asynchronously) and no partial-burst state is retained. After rstn rises, arbitration restarts from ptr=0.
- Assertions the implementation must include:
  - s_ready is one-hot or zero.
  - s_ready is zero in IDLE.
  - cnt < BURST_LEN always.

Test Plan:
- Reset: hold rstn=0 for 5 cycles with all s_valid=4'b1111 → s_ready=0, m_valid=0, m_data=0, busy=0 throughout.
- Single source:
  - Stimulus: only s_valid[2]=1, 12 random beats, m_ready=1.
  - Grant pattern: m_grant=2 for bursts of 4 beats, each separated by 1 bubble.
  - Completion: all 12 beats arrive in order in 14 cycles after the first IDLE cycle.
  - Data check: out_data == in_data.
- Round-robin:
  - Stimulus: all four sources always valid with distinct data (source k word = 8'hk0+n), m_ready=1.
  - Grant order: 0,1,2,3,0 with 4 beats each.
  - Beat check: every master beat equals the expected source's next beat.
- Backpressure:
  - Stimulus: as the round-robin case, with m_ready random at 10% high.
  - Each grant still carries exactly 4 accepted beats.
  - m_data is stable while m_valid && !m_ready.
  - No beat is lost or duplicated across 40 beats.
- Early release:
  - Stimulus: source 1 drops s_valid after 2 accepted beats while sources 2 and 3 are valid.
  - Release follows next cycle and the next grant is 2.
  - Source 1's remaining beats are served on its next turn, after 3.
- Reset mid-burst:
  - Stimulus: assert rstn=0 asynchronously during beat 2 of grant 3.
  - All outputs go to 0 within the same cycle.
  - After release of reset with s_valid=4'b1010, the first grant is 1.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin arbiter sharing one AXI-Stream master port between N_SRC sources
// Ports:
//   clk, rstn        clock (rising edge) and asynchronous active-low reset
//   s_valid/s_ready  per-source handshake, s_data packed [N_SRC-1:0][BUS_W-1:0]
//   m_valid/m_ready  master handshake, m_data master beat (combinational pass-through)
//   m_grant          granted source index, zero outside GRANT
//   busy             high while a source holds the grant
module axis_rr_arbiter #(
  parameter  int N_SRC     = 4,
  parameter  int WORD_W    = 8,
  parameter  int BUS_W     = 32,
  parameter  int BURST_LEN = 4,
  localparam int GNT_W     = $clog2(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_SRC-1:0]            s_valid,
  output logic [N_SRC-1:0]            s_ready,
  input  logic [N_SRC-1:0][BUS_W-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [BUS_W-1:0]            m_data,
  output logic [GNT_W-1:0]            m_grant,
  output logic                        busy
);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam int   CNT_W    = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;

  if (N_SRC < 2 || BURST_LEN < 1 || BUS_W % WORD_W != 0) begin : g_bad_param
    $error("axis_rr_arbiter: illegal parameter combination");
  end

  logic             state_q, state_d;
  logic [GNT_W-1:0] ptr_q, ptr_d, grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] rot;
  logic [GNT_W-1:0] off, rr_idx;
  logic [GNT_W:0]   sum;
  logic             beat, last;

  // Rotate requests so bit 0 is the source at ptr; the lowest set bit is the winner's offset.
  always_comb begin
    rot = N_SRC'({s_valid, s_valid} >> ptr_q);
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) off = rot[i] ? GNT_W'(i) : off;
    sum = {1'b0, ptr_q} + {1'b0, off};
    rr_idx = sum >= (GNT_W+1)'(N_SRC) ? GNT_W'(sum - (GNT_W+1)'(N_SRC)) : GNT_W'(sum);
  end

  assign busy    = state_q == ST_GRANT;
  assign m_grant = busy ? grant_q : '0;
  assign m_valid = busy & s_valid[grant_q];
  assign m_data  = busy ? s_data[grant_q] : '0;
  assign s_ready = busy ? N_SRC'(m_ready) << grant_q : '0;
  assign beat    = m_valid & m_ready;
  // A dropped valid releases early; otherwise release on the last beat of the burst.
  assign last    = busy & (~s_valid[grant_q] | (beat & (cnt_q == CNT_W'(BURST_LEN - 1))));

  always_comb begin
    state_d = busy ? (last ? ST_IDLE : ST_GRANT) : (|s_valid ? ST_GRANT : ST_IDLE);
    grant_d = (!busy && |s_valid) ? rr_idx : grant_q;
    ptr_d   = last ? (grant_q == GNT_W'(N_SRC - 1) ? '0 : grant_q + GNT_W'(1)) : ptr_q;
    cnt_d   = (!busy || last) ? '0 : cnt_q + CNT_W'(beat);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(s_ready));
  a_ready_idle:   assert property (@(posedge clk) disable iff (!rstn) !busy |-> s_ready == '0);
  a_cnt_range:    assert property (@(posedge clk) disable iff (!rstn) int'(cnt_q) < BURST_LEN);
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed vector table plus stream sequences for axis_rr_arbiter
module tb_axis_rr_arbiter;
  logic             clk = 1'b0, rstn = 1'b0;
  logic [3:0]       s_valid = '0, s_ready;
  logic [3:0][31:0] s_data = '0;
  logic             m_valid, m_ready = 1'b0, busy;
  logic [31:0]      m_data;
  logic [1:0]       m_grant;
  int               n_pass = 0, n_tot = 0;
  int               pops[4], exp_n[4], src_q[$];

  axis_rr_arbiter dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_grant(m_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] sv;
    logic       mr;
    logic       busy;
    logic [1:0] g;
    logic       mv;
    logic [3:0] sr;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [31:0] pat(input int k);
    return {4{4'(k), 4'hC}};
  endfunction

  function automatic logic [31:0] beat_of(input int k, input int n);
    return {8'(k), 8'(n), 8'(k * 16 + n), 8'h5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; s_valid = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Sources emit beat_of(k, n); every accepted master beat must come from src_q[got].
  task automatic stream(input string tag, input int nbeats, input logic [3:0] en,
                        input bit bp, input int drop, output int last_cyc);
    int got = 0, cyc = 0, e;
    bit prev_stall = 0;
    logic [31:0] prev_d = '0;
    last_cyc = -1;
    for (int k = 0; k < 4; k++) begin pops[k] = 0; exp_n[k] = 0; end
    while (got < nbeats && cyc < 3000) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        s_valid[k] = en[k] && pops[k] < nbeats && !(k == drop && pops[k] == 2 && got < 4);
        s_data[k]  = beat_of(k, pops[k]);
      end
      m_ready = bp ? ($urandom_range(0, 9) == 0) : 1'b1;
      #1;
      if (prev_stall) chk({tag, " stall data"}, m_data, prev_d);
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      if (m_valid && m_ready) begin
        e = src_q[got];
        chk($sformatf("%s beat%0d grant", tag, got), 32'(m_grant), 32'(e));
        chk($sformatf("%s beat%0d data", tag, got), m_data, beat_of(e, exp_n[e]));
        exp_n[e]++;
        got++;
        last_cyc = cyc;
      end
      for (int k = 0; k < 4; k++) if (s_valid[k] && s_ready[k]) pops[k]++;
      cyc++;
    end
    chk({tag, " beats done"}, 32'(got), 32'(nbeats));
  endtask

  initial begin
    int lc;
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[5]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[6]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[7]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[8]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[10] = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[11] = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[12] = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2};
    tbl[13] = '{1'b1, 4'hD, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2};
    tbl[14] = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[15] = '{1'b1, 4'h2, 1'b1, 1'b1, 2'd2, 1'b0, 4'h4};
    tbl[16] = '{1'b1, 4'h2, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[17] = '{1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2};
    for (int k = 0; k < 4; k++) s_data[k] = pat(k);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rstn = tbl[i].rstn; s_valid = tbl[i].sv; m_ready = tbl[i].mr;
      #1;
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d grant", i), 32'(m_grant), 32'(tbl[i].g));
      chk($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
      chk($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
      chk($sformatf("v%0d m_data", i), m_data, tbl[i].busy ? pat(int'(tbl[i].g)) : 32'h0);
    end

    do_reset();
    src_q = {};
    for (int i = 0; i < 12; i++) src_q.push_back(2);
    stream("single", 12, 4'b0100, 1'b0, -1, lc);
    chk("single last beat cycle", 32'(lc), 32'd14);

    do_reset();
    src_q = {};
    for (int i = 0; i < 20; i++) src_q.push_back((i / 4) % 4);
    stream("rr", 20, 4'b1111, 1'b0, -1, lc);

    do_reset();
    src_q = {};
    for (int i = 0; i < 40; i++) src_q.push_back((i / 4) % 4);
    stream("bp", 40, 4'b1111, 1'b1, -1, lc);

    do_reset();
    src_q = {1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1, 1, 1, 1};
    stream("early", 14, 4'b1110, 1'b0, 1, lc);

    do_reset();
    for (int k = 0; k < 4; k++) s_data[k] = pat(k);
    s_valid = 4'hF; m_ready = 1'b1;
    repeat (17) @(negedge clk);
    #1;
    chk("midrst pre busy", 32'(busy), 32'd1);
    chk("midrst pre grant", 32'(m_grant), 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst m_valid", 32'(m_valid), 32'd0);
    chk("midrst s_ready", 32'(s_ready), 32'd0);
    chk("midrst m_data", m_data, 32'd0);
    chk("midrst grant", 32'(m_grant), 32'd0);
    @(negedge clk);
    s_valid = 4'b1010; rstn = 1'b1;
    #1;
    chk("after rst idle", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("after rst busy", 32'(busy), 32'd1);
    chk("after rst grant", 32'(m_grant), 32'd1);
    chk("after rst s_ready", 32'(s_ready), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
